// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - single-port byte RAM shared by loader, fetch and data through a locked-burst arbiter
module ram_port_arbiter #(
   parameter int WIDTH   = 8,
   parameter int RAMSIZE = 64,
   parameter int ADDRW   = 6
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [2:0]           req,
   input  logic [2:0]           we,
   input  logic [3*ADDRW-1:0]   addr,
   input  logic [5:0]           len,
   input  logic [3*WIDTH-1:0]   wdata,
   output logic [2:0]           gnt,
   output logic [2:0]           rvalid,
   output logic [WIDTH-1:0]     rdata,
   output logic [2:0]           done,
   output logic                 busy
);

   typedef enum logic {IDLE, BURST} state_t;

   state_t              state;
   logic [1:0]          sel;      // index of the requester that owns the current burst
   logic [1:0]          count;    // beat number within the burst
   logic [1:0]          len_l;    // latched beats-minus-one
   logic                we_l;     // latched direction
   logic [ADDRW-1:0]    base;     // latched base address
   logic                ptr;      // 0: fetch preferred over data, 1: data preferred
   logic [ADDRW-1:0]    cur;
   logic [2:0]          eff;
   logic                any;
   logic [1:0]          win;

   logic [WIDTH-1:0]    mem [RAMSIZE];

   // Winner selection: a requester finishing this cycle is masked so others get a turn
   always_comb begin
      eff = req & ~done;
      any = |eff;
      win = 2'd0;
      if (eff[0])
         win = 2'd0;
      else if (eff[1] && eff[2])
         win = ptr ? 2'd2 : 2'd1;
      else if (eff[1])
         win = 2'd1;
      else if (eff[2])
         win = 2'd2;
   end

   // Beat address wraps at the top of memory because the carry is dropped
   always_comb begin
      cur = base + ADDRW'(count);
   end

   // RAM write port; contents survive reset so the loader owns initialisation
   always_ff @(posedge clk) begin
      if (state == BURST && we_l)
         mem[cur] <= wdata[sel*WIDTH +: WIDTH];
   end

   // Arbitration and burst sequencing with all outputs registered
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         gnt    <= 3'b000;
         rvalid <= 3'b000;
         done   <= 3'b000;
         rdata  <= '0;
         busy   <= 1'b0;
         count  <= 2'd0;
         ptr    <= 1'b0;
         sel    <= 2'd0;
         we_l   <= 1'b0;
         base   <= '0;
         len_l  <= 2'd0;
      end else begin
         case (state)
            IDLE: begin
               rvalid <= 3'b000;
               done   <= 3'b000;
               if (any) begin
                  sel   <= win;
                  we_l  <= we[win];
                  base  <= addr[win*ADDRW +: ADDRW];
                  len_l <= len[win*2 +: 2];
                  count <= 2'd0;
                  gnt   <= 3'b001 << win;
                  busy  <= 1'b1;
                  state <= BURST;
                  if (win == 2'd1)
                     ptr <= 1'b1;
                  else if (win == 2'd2)
                     ptr <= 1'b0;
               end
            end
            BURST: begin
               if (we_l) begin
                  rvalid <= 3'b000;
               end else begin
                  rvalid <= 3'b001 << sel;
                  rdata  <= mem[cur];
               end
               if (count == len_l) begin
                  gnt   <= 3'b000;
                  done  <= 3'b001 << sel;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  count <= count + 2'd1;
                  done  <= 3'b000;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - self-checking bench for ram_port_arbiter
module tb_ram_port_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [2:0]  req = '0;
   logic [2:0]  we = '0;
   logic [17:0] addr = '0;
   logic [5:0]  len = '0;
   logic [23:0] wdata = '0;
   logic [2:0]  gnt;
   logic [2:0]  rvalid;
   logic [7:0]  rdata;
   logic [2:0]  done;
   logic        busy;

   int n_assert = 0;
   int n_fail = 0;
   logic [7:0] mem_m [64];

   ram_port_arbiter #(.WIDTH(8), .RAMSIZE(64), .ADDRW(6)) dut (
      .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .len(len),
      .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .done(done), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs();
      chk("rst_gnt", {29'b0, gnt}, 0);
      chk("rst_rvalid", {29'b0, rvalid}, 0);
      chk("rst_done", {29'b0, done}, 0);
      chk("rst_rdata", {24'b0, rdata}, 0);
      chk("rst_busy", {31'b0, busy}, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk_reset_outputs();
      @(negedge clk);
      reset = 1'b0;
   endtask

   // One complete burst by requester r; reads are checked against the memory model
   task automatic do_burst(input int r, input bit w, input int a, input int l, input logic [31:0] d);
      int waited;
      logic [7:0] expd [4];
      for (int i = 0; i < 4; i++) expd[i] = mem_m[(a + i) % 64];
      req[r] = 1'b1;
      we[r] = w;
      addr[r*6 +: 6] = 6'(a);
      len[r*2 +: 2] = 2'(l);
      wdata[r*8 +: 8] = d[7:0];
      waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (gnt[r] !== 1'b1 && waited < 20);
      if (gnt[r] !== 1'b1) begin
         chk("grant_timeout", {29'b0, gnt}, 32'd1 << r);
         req[r] = 1'b0;
         return;
      end
      for (int k = 0; k <= l; k++) begin
         chk("burst_gnt", {29'b0, gnt}, 32'd1 << r);
         chk("burst_busy", {31'b0, busy}, 1);
         chk("burst_done", {29'b0, done}, 0);
         if (k > 0 && !w) begin
            chk("beat_rvalid", {29'b0, rvalid}, 32'd1 << r);
            chk("beat_rdata", {24'b0, rdata}, {24'b0, expd[k-1]});
         end else begin
            chk("beat_rvalid_low", {29'b0, rvalid}, 0);
         end
         wdata[r*8 +: 8] = d[k*8 +: 8];
         @(negedge clk);
      end
      chk("end_gnt", {29'b0, gnt}, 0);
      chk("end_done", {29'b0, done}, 32'd1 << r);
      chk("end_busy", {31'b0, busy}, 0);
      if (!w) begin
         chk("end_rvalid", {29'b0, rvalid}, 32'd1 << r);
         chk("end_rdata", {24'b0, rdata}, {24'b0, expd[l]});
      end else begin
         chk("end_rvalid_low", {29'b0, rvalid}, 0);
         for (int i = 0; i <= l; i++) mem_m[(a + i) % 64] = d[i*8 +: 8];
      end
      req[r] = 1'b0;
      @(negedge clk);
      chk("post_done", {29'b0, done}, 0);
      chk("post_rvalid", {29'b0, rvalid}, 0);
   endtask

   initial begin
      int np_exp [10];
      int ex;

      // Reset values
      #2;
      reset = 1'b1;
      #1;
      chk_reset_outputs();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Loader fills the whole memory with random bytes
      for (int b = 0; b < 16; b++) do_burst(0, 1'b1, b * 4, 3, $urandom());

      // Loader program write then 4-byte fetch read-back
      do_burst(0, 1'b1, 0, 3, 32'h0010_0002);
      do_burst(1, 1'b0, 0, 3, 32'h0);

      // Fetch and data contend continuously: alternate, fetch first after reset
      do_reset();
      we = 3'b000;
      len = 6'b0;
      addr[6 +: 6] = 6'd1;
      addr[12 +: 6] = 6'd2;
      req[1] = 1'b1;
      req[2] = 1'b1;
      for (int j = 0; j < 12; j++) begin
         @(negedge clk);
         ex = (j % 2 == 1) ? 0 : (((j / 2) % 2 == 0) ? 2 : 4);
         chk("rr_gnt", {29'b0, gnt}, ex);
      end
      req = 3'b000;
      @(negedge clk);
      @(negedge clk);

      // Data burst is not preempted; loader then beats a pending fetch
      np_exp = '{4, 4, 4, 4, 0, 1, 0, 2, 0, 0};
      we[2] = 1'b0;
      addr[12 +: 6] = 6'd8;
      len[4 +: 2] = 2'd3;
      req[2] = 1'b1;
      for (int j = 0; j < 10; j++) begin
         @(negedge clk);
         chk("np_gnt", {29'b0, gnt}, np_exp[j]);
         if (j == 4) chk("np_done_data", {29'b0, done}, 4);
         if (j == 6) chk("np_done_loader", {29'b0, done}, 1);
         if (j == 8) chk("np_done_fetch", {29'b0, done}, 2);
         if (j == 1) begin
            we[0] = 1'b1;
            addr[0 +: 6] = 6'd40;
            len[0 +: 2] = 2'd0;
            wdata[0 +: 8] = 8'h5A;
            we[1] = 1'b0;
            addr[6 +: 6] = 6'd41;
            len[2 +: 2] = 2'd0;
            req[0] = 1'b1;
            req[1] = 1'b1;
         end
         if (j == 4) req[2] = 1'b0;
         if (j == 6) req[0] = 1'b0;
         if (j == 8) req[1] = 1'b0;
      end
      mem_m[40] = 8'h5A;
      do_burst(1, 1'b0, 40, 0, 32'h0);

      // Burst wraps from the top of memory to address 0
      do_burst(2, 1'b1, 62, 3, 32'hA4A3_A2A1);
      do_burst(1, 1'b0, 62, 3, 32'h0);
      do_burst(2, 1'b0, 0, 1, 32'h0);

      // Reset after two beats of a write abandons the rest, no done pulse
      we[2] = 1'b1;
      addr[12 +: 6] = 6'd20;
      len[4 +: 2] = 2'd3;
      wdata[16 +: 8] = 8'h11;
      req[2] = 1'b1;
      @(negedge clk);
      chk("mid_gnt", {29'b0, gnt}, 4);
      @(negedge clk);
      wdata[16 +: 8] = 8'h12;
      @(negedge clk);
      wdata[16 +: 8] = 8'h13;
      reset = 1'b1;
      #1;
      chk_reset_outputs();
      req[2] = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      mem_m[20] = 8'h11;
      mem_m[21] = 8'h12;
      @(negedge clk);
      chk("mid_no_done", {29'b0, done}, 0);
      chk("mid_idle_busy", {31'b0, busy}, 0);
      do_burst(1, 1'b0, 20, 3, 32'h0);

      // Held request is masked in its done cycle and re-granted one cycle later
      we[1] = 1'b0;
      addr[6 +: 6] = 6'd5;
      len[2 +: 2] = 2'd0;
      req[1] = 1'b1;
      for (int j = 0; j < 9; j++) begin
         @(negedge clk);
         chk("hold_gnt", {29'b0, gnt}, (j % 3 == 0) ? 2 : 0);
      end
      req[1] = 1'b0;
      @(negedge clk);
      chk("hold_release", {29'b0, gnt}, 0);

      // Random single bursts against the memory model
      for (int n = 0; n < 60; n++)
         do_burst(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 63)), int'($urandom_range(0, 3)), $urandom());

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Single-port RAM with a three-requester arbiter that shares the processor's byte-wide program/data memory between the loader, instruction fetch and data access. Each grant is a locked burst of 1–4 bytes, so a 4-byte instruction fetch or a multi-byte store completes without interleaving. It replaces direct RAM indexing in the core and is the only path into memory.

## Interface
- WIDTH, 8, data width in bits
- RAMSIZE, 64, RAM depth in words; must be a power of two
- ADDRW, 6, address width; equals log2(RAMSIZE)

- clk  input  1  clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-high
- req  input  3  request per requester: bit0 = loader, bit1 = fetch, bit2 = data
- we  input  3  per requester: 1 = write burst, 0 = read burst
- addr  input  3*ADDRW  per requester base address; slice i is bits [i*ADDRW +: ADDRW]
- len  input  6  per requester: beats minus 1 (0..3); slice i is bits [2i +: 2]
- wdata  input  3*WIDTH  per requester write data for the current beat
- gnt  output  3  one-hot grant; high for exactly N cycles per burst
- rvalid  output  3  per requester: rdata valid this cycle
- rdata  output  WIDTH  read data, shared by all requesters
- done  output  3  one-cycle pulse after the last beat of the requester's burst
- busy  output  1  high while in BURST

## Operation
- FSM has two states.
  - IDLE: arbitrate.
  - BURST: one RAM access per cycle.
- IDLE, at each edge: the effective request is req with the bit of any requester whose done is high this cycle masked off. If any effective request is set:
  - Pick the winner.
  - Latch its we, addr and len.
  - Clear the beat counter.
  - Set gnt to one-hot of the winner.
  - Go to BURST.
- Priority:
  - Loader (bit0) always wins.
  - Between fetch and data: round-robin on a 1-bit pointer, updated whenever fetch or data is granted so the other is preferred next time.
  - After reset the pointer prefers fetch.
- Arbitration is not preemptive. A higher-priority request arriving mid-burst waits for IDLE.
- BURST, at each edge:
  - Current address is (base + count) mod RAMSIZE, so bursts wrap from RAMSIZE-1 to 0.
  - Write: ram[cur] <= live wdata slice of the granted requester.
  - Read: rdata <= ram[cur], and the requester's rvalid bit <= 1.
  - If count == len: gnt <= 0, done bit <= 1, go to IDLE. Otherwise count <= count + 1.
- Write requesters drive beat k's data during the k-th cycle (counting from 0) in which gnt is high.
- Requesters hold req, we, addr and len stable until done. Dropping req mid-burst is ignored; the burst completes.
- Arithmetic:
  - count is 2 bits.
  - Address adds are ADDRW bits with the carry discarded.
  - The upper bits of addr beyond ADDRW do not exist (the slice is exactly ADDRW).
- RAM contents are not cleared by reset. The loader initialises memory.
- Reset, asynchronous:
  - state = IDLE, gnt = 0, rvalid = 0, done = 0, rdata = 0, busy = 0, count = 0, pointer = fetch-preferred.
  - Reset mid-burst abandons the burst: beats already written remain in RAM, and no done pulse is issued.

## Timing
- Request set before edge E0, with the FSM in IDLE: gnt high from E0.
- Beats at E1..EN.
- rvalid and rdata appear after each of E1..EN, i.e. one cycle after the beat's gnt cycle.
- After EN: gnt low, done high, and the last rvalid is high in the same cycle.
- 4-byte read: done is 4 cycles after the grant edge; 5 edges from request sampling to the done cycle.
- Throughput: N+1 cycles per burst, because one IDLE arbitration cycle separates back-to-back bursts.
- gnt, rvalid, done, rdata and busy are all registered; there are no combinational paths from inputs to outputs.
- rvalid is low in every cycle not immediately following a read beat. rdata holds its last value otherwise.

## Test plan
- Loader writes 0x02,0x00,0x10,0x00 at addr 0 (len=3) -> gnt[0] high 4 cycles, done[0] once. Fetch read addr 0 len=3 -> rvalid[1] for 4 consecutive cycles with rdata 0x02,0x00,0x10,0x00, done[1] coincident with the last beat.
- Fetch and data request together continuously, each len=0 -> grants alternate fetch, data, fetch, data. The first grant goes to fetch after reset. One burst every 2 cycles.
- Data burst len=3 in progress, loader raises req at beat 1 -> data burst completes all 4 beats. The loader is granted at the next IDLE, ahead of a pending fetch.
- Write 0xA1..0xA4 at addr 62, len=3 -> RAM 62=0xA1, 63=0xA2, 0=0xA3, 1=0xA4. A read-back burst returns the same values in that order.
- Write burst 0x11..0x14 at addr 20, reset asserted after beat 2 -> all outputs 0 immediately, RAM 20=0x11 and 21=0x12, no done. After release, the FSM is IDLE and the next request is granted normally.
- Requester holds req through done -> masked in the done cycle. Another pending requester wins. If none is pending, the same requester is re-granted one cycle later.
